// File: rtl/rtc_bus_pkg.sv
// Shared RTC bus constants: register map, phase timing, window encoding.
// Used by the sweep reader and the initialization writer.
package rtc_bus_pkg;

  localparam int unsigned PHASE_LEN_DEF = 7;

  localparam logic [7:0] RTC_SEG   = 8'h21;
  localparam logic [7:0] RTC_MIN   = 8'h22;
  localparam logic [7:0] RTC_HORA  = 8'h23;
  localparam logic [7:0] RTC_FECHA = 8'h24;
  localparam logic [7:0] RTC_MES   = 8'h25;
  localparam logic [7:0] RTC_ANIO  = 8'h26;
  localparam logic [7:0] RTC_TSEG  = 8'h41;
  localparam logic [7:0] RTC_TMIN  = 8'h42;
  localparam logic [7:0] RTC_THORA = 8'h43;
  localparam logic [7:0] RTC_CMD0  = 8'hF0;
  localparam logic [7:0] RTC_CMD1  = 8'hF1;
  localparam logic [7:0] RTC_CMD2  = 8'hF2;

  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic [1:0] {
    PH_ADDR,
    PH_GAP,
    PH_DATA,
    PH_REC
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_READ,
    ST_DONE
  } state_e;

  function automatic logic [7:0] rd_addr(
    input logic [3:0] idx
  );
    logic [7:0] a;
    a = 8'h00;
    case (idx)
      4'd0:    a = RTC_SEG;
      4'd1:    a = RTC_MIN;
      4'd2:    a = RTC_HORA;
      4'd3:    a = RTC_FECHA;
      4'd4:    a = RTC_MES;
      4'd5:    a = RTC_ANIO;
      4'd6:    a = RTC_TSEG;
      4'd7:    a = RTC_TMIN;
      4'd8:    a = RTC_THORA;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One RTC bus transaction: four PHASE_LEN windows (addr, gap, data, rec).
// Ports: en_i/rd_i/addr_i/wdata_i in; bus strobes, cap_o, end_o out.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_LEN = PHASE_LEN_DEF
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       en_i,
  input  logic       rd_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       ad_o,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       cap_o,
  output logic       end_o
);

  localparam logic [3:0] SUB_LAST = 4'(PHASE_LEN - 1);

  logic [3:0] sub_q;
  phase_e     ph_q;
  logic       ad_q;
  logic       last;

  assign last = (sub_q == SUB_LAST);

  // Counter idles at window 0 so each transaction starts from P0.
  always_ff @(posedge clk_i) begin
    if (reset || !en_i) begin
      sub_q <= 4'd0;
      ph_q  <= PH_ADDR;
    end else if (last) begin
      sub_q <= 4'd0;
      ph_q  <= phase_e'(ph_q + 2'd1);
    end else begin
      sub_q <= sub_q + 4'd1;
    end
  end

  // ad_o keeps the last driven select through gap/recovery.
  always_ff @(posedge clk_i) begin
    if (reset) ad_q <= 1'b0;
    else       ad_q <= ad_o;
  end

  always_comb begin
    data_o  = 8'h00;
    data_oe = 1'b0;
    ad_o    = ad_q;
    cs_n    = 1'b1;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    if (en_i) begin
      unique case (ph_q)
        PH_ADDR: begin
          cs_n    = 1'b0;
          wr_n    = 1'b0;
          ad_o    = 1'b0;
          data_oe = 1'b1;
          data_o  = addr_i;
        end
        PH_DATA: begin
          cs_n = 1'b0;
          ad_o = 1'b1;
          if (rd_i) begin
            rd_n = 1'b0;
          end else begin
            wr_n    = 1'b0;
            data_oe = 1'b1;
            data_o  = wdata_i;
          end
        end
        PH_GAP: ;
        PH_REC: ;
      endcase
    end
  end

  assign cap_o = en_i && rd_i && (ph_q == PH_DATA) && last;
  assign end_o = en_i && (ph_q == PH_REC) && last;

endmodule

// File: rtl/rtc_bus_reader.sv
// Sweeps the RTC: 0xF0 command write, then reads of nine time registers.
// Ports: start_i, data_i in; bus strobes, captured values, busy_o/done_o out.
module rtc_bus_reader
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_LEN = PHASE_LEN_DEF
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       ad_o,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] seg_o,
  output logic [7:0] min_o,
  output logic [7:0] hora_o,
  output logic [7:0] fecha_o,
  output logic [7:0] mes_o,
  output logic [7:0] anio_o,
  output logic [7:0] tseg_o,
  output logic [7:0] tmin_o,
  output logic [7:0] thora_o,
  output logic       busy_o,
  output logic       done_o
);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] vals_q [0:8];
  logic       tx_en, tx_rd, tx_cap, tx_end;
  logic [7:0] tx_addr;

  assign tx_en   = (state_q == ST_CMD) || (state_q == ST_READ);
  assign tx_rd   = (state_q == ST_READ);
  assign tx_addr = tx_rd ? rd_addr(idx_q) : RTC_CMD0;

  rtc_bus_cycle #(
    .PHASE_LEN (PHASE_LEN)
  ) u_cycle (
    .clk_i   (clk_i),
    .reset   (reset),
    .en_i    (tx_en),
    .rd_i    (tx_rd),
    .addr_i  (tx_addr),
    .wdata_i (RTC_CMD0),
    .data_o  (data_o),
    .data_oe (data_oe),
    .ad_o    (ad_o),
    .cs_n    (cs_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .cap_o   (tx_cap),
    .end_o   (tx_end)
  );

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_CMD;
      ST_CMD:  if (tx_end)  state_d = ST_READ;
      ST_READ: begin
        if (tx_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) vals_q[i] <= 8'h00;
    end else if (tx_cap) begin
      vals_q[idx_q] <= data_i;
    end
  end

  assign seg_o   = vals_q[0];
  assign min_o   = vals_q[1];
  assign hora_o  = vals_q[2];
  assign fecha_o = vals_q[3];
  assign mes_o   = vals_q[4];
  assign anio_o  = vals_q[5];
  assign tseg_o  = vals_q[6];
  assign tmin_o  = vals_q[7];
  assign thora_o = vals_q[8];

  assign busy_o = tx_en;
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Scoreboard bench for rtc_bus_reader at PHASE_LEN 7 and 3.
// A bus-level RTC model answers reads from a randomized register map.
module tb_rtc_bus_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit fin [2];

  task automatic chk(
    input string       nm,
    input logic [71:0] act,
    input logic [71:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int PL = (g == 0) ? 7 : 3;
    localparam int TL = 4 * PL;

    logic       reset;
    logic       start_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_oe, ad_o, cs_n, rd_n, wr_n;
    logic [7:0] seg_o, min_o, hora_o, fecha_o, mes_o;
    logic [7:0] anio_o, tseg_o, tmin_o, thora_o;
    logic       busy_o, done_o;
    logic [71:0] got;

    logic [7:0]  mem [0:255];
    logic [7:0]  alat = 8'h00;
    logic [71:0] exp_q [$];
    int          busy_cnt = 0;

    rtc_bus_reader #(
      .PHASE_LEN (PL)
    ) u_dut (
      .clk_i   (clk),
      .reset   (reset),
      .start_i (start_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .data_oe (data_oe),
      .ad_o    (ad_o),
      .cs_n    (cs_n),
      .rd_n    (rd_n),
      .wr_n    (wr_n),
      .seg_o   (seg_o),
      .min_o   (min_o),
      .hora_o  (hora_o),
      .fecha_o (fecha_o),
      .mes_o   (mes_o),
      .anio_o  (anio_o),
      .tseg_o  (tseg_o),
      .tmin_o  (tmin_o),
      .thora_o (thora_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
    );

    assign got = {seg_o, min_o, hora_o, fecha_o, mes_o,
                  anio_o, tseg_o, tmin_o, thora_o};

    always_comb data_i = !rd_n ? mem[alat] : 8'h00;

    // Monitor: bus protocol every cycle, scoreboard pop on done_o.
    always @(negedge clk) begin
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (!cs_n && !ad_o && !wr_n) alat = data_o;
        chk("oe_while_rd", {71'd0, data_oe && !rd_n}, 72'd0);
        chk("rd_wr_both", {71'd0, !rd_n && !wr_n}, 72'd0);
        if (busy_o) begin
          int t;
          int w;
          t = busy_cnt % TL;
          w = t / PL;
          if (w == 1 || w == 3)
            chk("cs_gap", {71'd0, cs_n}, 72'd1);
          if (busy_cnt < TL && (w == 0 || w == 2))
            chk("cmd_bus",
                {59'd0, data_o, ad_o, wr_n, rd_n, cs_n, data_oe},
                {59'd0, 8'hF0, w == 2, 1'b0, 1'b1, 1'b0, 1'b1});
          busy_cnt++;
        end
        if (done_o) begin
          chk("busy_len", 72'(busy_cnt), 72'(40 * PL));
          busy_cnt = 0;
          if (exp_q.size() == 0)
            chk("spurious_done", 72'd1, 72'd0);
          else
            chk("values", got, exp_q.pop_front());
        end
      end
    end

    task automatic run_sweep(input bit poke);
      exp_q.push_back({mem[8'h21], mem[8'h22], mem[8'h23],
                       mem[8'h24], mem[8'h25], mem[8'h26],
                       mem[8'h41], mem[8'h42], mem[8'h43]});
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      chk("start_lat", {71'd0, busy_o}, 72'd1);
      if (poke) begin
        repeat (98) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
      end
      for (int i = 0; i < 50 * PL && exp_q.size() != 0; i++)
        @(posedge clk);
      chk("sweep_timeout", 72'(exp_q.size()), 72'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
    endtask

    initial begin
      reset   = 1'b1;
      start_i = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_bus",
          {58'd0, data_o, data_oe, ad_o, cs_n, rd_n, wr_n, busy_o},
          {58'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
      chk("reset_done", {71'd0, done_o}, 72'd0);
      chk("reset_vals", got, 72'd0);
      reset = 1'b0;

      mem[8'h21] = 8'h30; mem[8'h22] = 8'h45; mem[8'h23] = 8'h12;
      mem[8'h24] = 8'h26; mem[8'h25] = 8'h04; mem[8'h26] = 8'h16;
      mem[8'h41] = 8'h55; mem[8'h42] = 8'h59; mem[8'h43] = 8'h23;
      run_sweep(1'b1);

      for (int s = 0; s < 3; s++) begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        run_sweep(1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      repeat (18 * PL) @(posedge clk);
      #1;
      chk("abort_in_rd", {71'd0, rd_n}, 72'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_strobes",
          {67'd0, cs_n, rd_n, wr_n, busy_o, done_o},
          {67'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
      chk("abort_fecha", {64'd0, fecha_o}, 72'd0);
      chk("abort_vals", got, 72'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_sweep(1'b0);

      fin[g] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(fin[0] && fin[1]) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    chk("global_timeout", {70'd0, fin[0], fin[1]}, 72'd3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_reader.md
RTC_BUS_READER -- requirements
Module: rtc_bus_reader

Interface
REQ-001 Parameter PHASE_LEN, default 7: clock cycles per bus phase; legal range 2..15.
REQ-002 clk_i  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  one-cycle request to run a full read sweep; ignored while busy_o=1.
REQ-005 data_i  input  8  RTC multiplexed bus, input side, sampled during the read data phase.
REQ-006 data_o  output  8  RTC multiplexed bus, driven side: address or write data.
REQ-007 data_oe  output  1  bus drive enable; 1 = data_o drives the pad, 0 = pad tri-stated at top level.
REQ-008 ad_o  output  1  address/data select; 0 = address phase, 1 = data phase.
REQ-009 cs_n  output  1  chip select, active-low.
REQ-010 rd_n  output  1  read strobe, active-low.
REQ-011 wr_n  output  1  write strobe, active-low.
REQ-012 seg_o, min_o, hora_o, fecha_o, mes_o, anio_o, tseg_o, tmin_o, thora_o  output  8 each  captured BCD values from registers 0x21..0x26 and 0x41..0x43.
REQ-013 busy_o  output  1  high from the cycle after start_i is accepted through the end of the last transaction.
REQ-014 done_o  output  1  one-cycle pulse after the sweep completes.

Function
REQ-015 Top FSM states SHALL be IDLE, CMD, READ and DONE: IDLE->CMD on start_i; CMD->READ after one transaction; READ repeats over a 4-bit index 0..8; READ->DONE after index 8; DONE->IDLE unconditionally after one cycle.
REQ-016 Each transaction SHALL last 4*PHASE_LEN cycles, counted by a phase counter starting at 0, in four windows: P0 = address strobe, P1 = gap, P2 = data strobe, P3 = recovery.
REQ-017 P0: cs_n=0, wr_n=0, rd_n=1, ad_o=0, data_oe=1, data_o=address.
REQ-018 P1 and P3: cs_n=1, wr_n=1, rd_n=1, data_oe=0; ad_o holds its last value.
REQ-019 CMD transaction SHALL use address 0xF0 and write data 0xF0; in P2: cs_n=0, wr_n=0, rd_n=1, ad_o=1, data_oe=1, data_o=0xF0.
REQ-020 READ transactions SHALL use address order 0x21,0x22,0x23,0x24,0x25,0x26,0x41,0x42,0x43, indexed 0..8.
REQ-021 In P2 of a READ transaction: cs_n=0, rd_n=0, wr_n=1, ad_o=1, data_oe=0.
REQ-022 data_i SHALL be registered on the last cycle of P2 into the output mapped to the current index; all other value outputs hold.
REQ-023 data_oe SHALL never be 1 while rd_n=0; rd_n and wr_n SHALL never both be 0.
REQ-024 start_i asserted while busy_o=1 or done_o=1 SHALL be ignored, with no queuing.
REQ-025 Latency: start_i high at edge N puts CMD phase-counter 0 at cycle N+1; busy_o is high for 40*PHASE_LEN cycles (280 at default); done_o is high in the next cycle.
REQ-026 Value outputs SHALL update only on capture and never on abort.

Reset
REQ-027 Reset SHALL force: state IDLE; phase counter and index 0; cs_n=1, rd_n=1, wr_n=1; ad_o=0; data_oe=0; data_o=0x00; busy_o=0; done_o=0; all value outputs 0x00.
REQ-028 Reset mid-transaction SHALL take effect at the next edge and deassert all strobes immediately; no partial capture is committed.

Structure
REQ-029 Package rtc_bus_pkg SHALL hold: register address constants (0x21..0x26, 0x41..0x43, 0xF0/0xF1/0xF2), the default PHASE_LEN, and the phase-window encoding, shared with the initialization writer.
REQ-030 One sub-module, rtc_bus_cycle, SHALL generate strobe timing for one transaction, taking address, write data and a read/write flag, and returning a capture strobe and an end-of-transaction pulse.

Verification
REQ-031 Reset, then pulse start_i; RTC model returns 0x30,0x45,0x12,0x26,0x04,0x16,0x55,0x59,0x23 -> seg_o=0x30 … thora_o=0x23; done_o pulses at cycle 281 after start_i.
REQ-032 First transaction -> bus shows 0xF0 with ad_o=0 and wr_n=0 for 7 cycles, then 0xF0 with ad_o=1 and wr_n=0 for 7 cycles; rd_n stays 1.
REQ-033 start_i pulsed again at cycle 100 of a sweep -> no effect; done_o pulses exactly once, at cycle 281.
REQ-034 Reset asserted while P2 of index 3 (fecha) is active -> strobes go high next cycle, fecha_o=0x00, busy_o=0.
REQ-035 Protocol assertions over a full sweep -> data_oe&&!rd_n never true, !rd_n&&!wr_n never true, cs_n high in every P1/P3 window.
REQ-036 PHASE_LEN=3 -> sweep length 120 cycles, captures correct.
